// File: rtl/sobel_uart_tx_if.sv
// Byte-stream side of the Sobel UART transmitter: strobe/data in, line and status out.
interface sobel_uart_tx_if;
    logic       in_flag;
    logic [7:0] in_data;
    logic       tx;
    logic       busy;
    logic       fifo_full;
    logic       overflow;

    modport master (output in_flag, in_data, input tx, busy, fifo_full, overflow);
    modport slave  (input in_flag, in_data, output tx, busy, fifo_full, overflow);
endinterface

// File: rtl/sobel_uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO that absorbs bursts from the Sobel filter path.
module sobel_uart_tx #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600,
    parameter int FIFO_AW  = 4
) (
    input  logic            sclk,
    input  logic            rst,
    sobel_uart_tx_if.slave  bus
);
    localparam int BIT_CNT = CLK_FREQ / BAUD;
    localparam int BCW     = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
    localparam int DEPTH   = 2 ** FIFO_AW;
    localparam logic [BCW-1:0]   BAUD_LAST  = BCW'(BIT_CNT - 1);
    localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [BCW-1:0]     baud_cnt_q, baud_cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               overflow_q, overflow_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic [7:0]         mem_q [DEPTH];
    logic [7:0]         mem_d [DEPTH];
    logic               push, pop, baud_done;

    always_comb begin
        push       = bus.in_flag && (count_q != COUNT_FULL);
        pop        = (state_q == IDLE) && (count_q != '0);
        baud_done  = (baud_cnt_q == BAUD_LAST);
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (bus.in_flag && (count_q == COUNT_FULL));
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;

        if (push) begin
            mem_d[wr_ptr_q] = bus.in_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            IDLE: begin
                if (pop) begin
                    shift_d    = mem_q[rd_ptr_q];
                    baud_cnt_d = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level and busy are taken from the next state so the registers line up with it.
        tx_d = 1'b1;
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = shift_d[0];
        end
        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge sclk) begin
        mem_q <= mem_d;
    end

    assign bus.tx        = tx_q;
    assign bus.busy      = busy_q;
    assign bus.overflow  = overflow_q;
    assign bus.fifo_full = (count_q == COUNT_FULL);
endmodule

// File: tb/tb_sobel_uart_tx.sv
// Bench for sobel_uart_tx: directed scenarios plus random traffic against a frame-timeline model.
module tb_sobel_uart_tx;
    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int FIFO_AW  = 2;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int DEPTH    = 2 ** FIFO_AW;
    localparam int FRAME    = 10 * BIT;

    logic sclk = 1'b0;
    logic rst  = 1'b1;
    sobel_uart_tx_if bus ();

    sobel_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_AW(FIFO_AW)) dut (
        .sclk (sclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 sclk = ~sclk;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cycle        = 0;

    // Model: bytes waiting, position inside the current frame (-1 = line idle), sticky drop flag.
    logic [7:0] mq [$];
    int         fpos  = -1;
    logic [7:0] fbyte = 8'h00;
    logic       movf  = 1'b0;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %b expected %b at cycle %0d", tag, observed, expected, cycle);
        end
    endtask

    function automatic logic modelTx();
        logic [2:0] bi;
        if (fpos < 0) return 1'b1;
        if (fpos < BIT) return 1'b0;
        if (fpos < 9 * BIT) begin
            bi = 3'((fpos - BIT) / BIT);
            return fbyte[bi];
        end
        return 1'b1;
    endfunction

    task automatic applyStimulus(input logic flag, input logic [7:0] data, input logic rst_v);
        int size0;
        bus.in_flag = flag;
        bus.in_data = data;
        rst         = rst_v;
        if (rst_v) begin
            mq.delete();
            fpos = -1;
            movf = 1'b0;
        end else begin
            size0 = mq.size();
            if (fpos < 0 && size0 != 0) begin
                fbyte = mq.pop_front();
                fpos  = 0;
            end else if (fpos >= 0) begin
                fpos++;
                if (fpos == FRAME) fpos = -1;
            end
            if (flag) begin
                if (size0 < DEPTH) mq.push_back(data);
                else movf = 1'b1;
            end
        end
        @(posedge sclk);
        #1;
        cycle++;
        checkOutput("tx", bus.tx, modelTx());
        checkOutput("busy", bus.busy, (fpos >= 0) || (mq.size() != 0));
        checkOutput("fifo_full", bus.fifo_full, mq.size() == DEPTH);
        checkOutput("overflow", bus.overflow, movf);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic burst(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, first + 8'(i), 1'b0);
        bus.in_flag = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (!(fpos < 0 && mq.size() == 0) && guard < 3000) begin
            applyStimulus(1'b0, 8'($urandom), 1'b0);
            guard++;
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("drain_idle", bus.busy, 1'b0);
    endtask

    initial begin
        int guard;
        int density;
        bus.in_flag = 1'b0;
        bus.in_data = 8'h00;
        @(posedge sclk);
        #1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b1);

        $display("[TB] idle after reset");
        idleCycles(200);

        $display("[TB] single byte A5");
        applyStimulus(1'b1, 8'hA5, 1'b0);
        drain();

        $display("[TB] burst of four");
        burst(8'h01, 4);
        drain();

        $display("[TB] burst of six with overflow");
        burst(8'h01, 6);
        checkOutput("t4_overflow_set", bus.overflow, 1'b1);
        drain();
        checkOutput("t4_overflow_held", bus.overflow, 1'b1);

        $display("[TB] reset mid frame");
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t5_overflow_cleared", bus.overflow, 1'b0);
        burst(8'h21, 3);
        guard = 0;
        while (fpos != BIT + 3 * BIT + BIT / 2 && guard < 500) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            guard++;
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("t5_tx_high", bus.tx, 1'b1);
        checkOutput("t5_busy_low", bus.busy, 1'b0);
        idleCycles(150);
        applyStimulus(1'b1, 8'h3C, 1'b0);
        drain();

        $display("[TB] push during pop across pointer wrap");
        applyStimulus(1'b0, 8'h00, 1'b1);
        burst(8'h11, 4);
        guard = 0;
        while (!(fpos < 0 && mq.size() == 1) && guard < 500) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            guard++;
        end
        applyStimulus(1'b1, 8'hC6, 1'b0);
        checkOutput("t6_busy", bus.busy, 1'b1);
        checkOutput("t6_not_full", bus.fifo_full, 1'b0);
        drain();

        $display("[TB] random traffic");
        for (int seg = 0; seg < 10; seg++) begin
            density = $urandom_range(1, 60);
            for (int i = 0; i < 400; i++) begin
                applyStimulus($urandom_range(0, 99) < density, 8'($urandom),
                              $urandom_range(0, 999) == 0);
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #(10 * 60000);
        $display("[TB] FAIL watchdog: simulation did not finish at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
